// File: rtl/apb_spi_regif.sv
// APB3 register front-end for spi_master: turns TXDATA writes into one-word transfer
// requests and captures the received word when the master reports ready again.
module apb_spi_regif #(
    parameter int WORD_LENGTH = 8,
    parameter int ADDR_WIDTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   PSEL,
    input  logic                   PENABLE,
    input  logic                   PWRITE,
    input  logic [ADDR_WIDTH-1:0]  PADDR,
    input  logic [31:0]            PWDATA,
    output logic [31:0]            PRDATA,
    output logic                   PREADY,
    output logic                   PSLVERR,
    output logic [WORD_LENGTH-1:0] WDATA,
    output logic                   data_valid,
    input  logic                   SPI_status_RDY_BSYbar,
    input  logic [WORD_LENGTH-1:0] RDATA,
    output logic                   irq
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LAUNCH    = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_CAPTURE   = 2'd3
    } state_t;

    localparam logic [1:0] A_TX   = 2'd0;
    localparam logic [1:0] A_RX   = 2'd1;
    localparam logic [1:0] A_STAT = 2'd2;
    localparam logic [1:0] A_CTRL = 2'd3;

    state_t                 state_q;
    logic [WORD_LENGTH-1:0] tx_q;
    logic [WORD_LENGTH-1:0] rx_q;
    logic [WORD_LENGTH-1:0] wdata_q;
    logic                   data_valid_q;
    logic                   rx_valid_q, rx_valid_d;
    logic                   overrun_q, overrun_d;
    logic                   irq_en_q;

    logic       access;
    logic [1:0] addr;
    logic       busy;
    logic       capture;
    logic       tx_wr, tx_accept, tx_err;
    logic       rx_rd, rx_wr;
    logic       stat_wr, ctrl_wr;

    assign access    = PSEL & PENABLE;
    assign addr      = PADDR[3:2];
    assign busy      = (state_q != S_IDLE);
    assign capture   = (state_q == S_CAPTURE);

    assign tx_wr     = access &  PWRITE & (addr == A_TX);
    assign tx_accept = tx_wr & ~busy;
    assign tx_err    = tx_wr &  busy;
    assign rx_rd     = access & ~PWRITE & (addr == A_RX);
    assign rx_wr     = access &  PWRITE & (addr == A_RX);
    assign stat_wr   = access &  PWRITE & (addr == A_STAT);
    assign ctrl_wr   = access &  PWRITE & (addr == A_CTRL);

    // Capture beats a same-cycle RXDATA read: the reader got the old word, the new one stays pending.
    always_comb begin
        rx_valid_d = rx_valid_q;
        if (capture)
            rx_valid_d = 1'b1;
        else if (rx_rd)
            rx_valid_d = 1'b0;
    end

    // Any overrun source in the same cycle as a W1C wins over the clear.
    always_comb begin
        overrun_d = overrun_q;
        if (tx_err || (capture && rx_valid_q))
            overrun_d = 1'b1;
        else if (stat_wr && PWDATA[2])
            overrun_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            tx_q         <= '0;
            rx_q         <= '0;
            wdata_q      <= '0;
            data_valid_q <= 1'b0;
            rx_valid_q   <= 1'b0;
            overrun_q    <= 1'b0;
            irq_en_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (tx_accept) begin
                        tx_q         <= PWDATA[WORD_LENGTH-1:0];
                        wdata_q      <= PWDATA[WORD_LENGTH-1:0];
                        data_valid_q <= 1'b1;
                        state_q      <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    if (!SPI_status_RDY_BSYbar) begin
                        data_valid_q <= 1'b0;
                        state_q      <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (SPI_status_RDY_BSYbar)
                        state_q <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    rx_q    <= RDATA;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
            if (ctrl_wr)
                irq_en_q <= PWDATA[0];
        end
    end

    always_comb begin
        PRDATA = '0;
        if (access && !PWRITE) begin
            case (addr)
                A_TX:    PRDATA[WORD_LENGTH-1:0] = tx_q;
                A_RX:    PRDATA[WORD_LENGTH-1:0] = rx_q;
                A_STAT:  PRDATA[2:0]             = {overrun_q, rx_valid_q, busy};
                default: PRDATA[0]               = irq_en_q;
            endcase
        end
    end

    assign PSLVERR    = tx_err | rx_wr;
    assign PREADY     = 1'b1;
    assign WDATA      = wdata_q;
    assign data_valid = data_valid_q;
    assign irq        = irq_en_q & rx_valid_q;

    logic unused_bits;
    assign unused_bits = ^{PADDR, PWDATA};

endmodule

// File: tb/tb_apb_spi_regif.sv
// Directed bench for apb_spi_regif with a small behavioural spi_master model.
module tb_apb_spi_regif;

    logic        clk;
    logic        rst_n;
    logic        PSEL, PENABLE, PWRITE;
    logic [3:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic [7:0]  WDATA;
    logic        data_valid;
    logic        rdy;
    logic [7:0]  RDATA;
    logic        irq;

    int checks = 0;
    int errors = 0;

    // Master model: auto mode reacts to data_valid; manual mode lets the sequence drive pins directly.
    bit         manual;
    logic       man_rdy, mdl_rdy;
    logic [7:0] man_rdata, mdl_rdata, resp;
    int         drop_dly, busy_len;

    assign rdy   = manual ? man_rdy   : mdl_rdy;
    assign RDATA = manual ? man_rdata : mdl_rdata;

    apb_spi_regif #(.WORD_LENGTH(8), .ADDR_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .WDATA(WDATA), .data_valid(data_valid),
        .SPI_status_RDY_BSYbar(rdy), .RDATA(RDATA), .irq(irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        mdl_rdy   = 1'b1;
        mdl_rdata = 8'h00;
        forever begin
            @(posedge clk);
            #2;
            if (!manual && data_valid === 1'b1) begin
                repeat (drop_dly) @(posedge clk);
                #2 mdl_rdy = 1'b0;
                repeat (busy_len) @(posedge clk);
                #2 mdl_rdata = resp;
                mdl_rdy = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Tasks start and end at posedge+1; the access edge has passed on return.
    task automatic apb_write(input logic [3:0] a, input logic [31:0] d, output logic err);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(posedge clk); #1 PENABLE = 1'b1;
        @(negedge clk);
        err = PSLVERR;
        chk("wr_prdata_zero", PRDATA, 32'h0);
        @(posedge clk); #1 PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic apb_read(input logic [3:0] a, output logic [31:0] d, output logic err);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a; PWDATA = 32'h0;
        @(posedge clk); #1 PENABLE = 1'b1;
        @(negedge clk);
        d = PRDATA; err = PSLVERR;
        @(posedge clk); #1 PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] d;
        logic        e;
        d = 32'h1;
        for (int i = 0; i < 100; i++) begin
            apb_read(4'h8, d, e);
            if (d[0] == 1'b0) break;
        end
        chk(tag, {31'h0, d[0]}, 32'h0);
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        manual = 1'b1; man_rdy = 1'b1; man_rdata = 8'h00;
        resp = 8'h00; drop_dly = 3; busy_len = 20;
        PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
        rst_n = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data_valid", {31'h0, data_valid}, 32'h0);
        chk("rst_wdata", {24'h0, WDATA}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_prdata", PRDATA, 32'h0);
        chk("rst_pslverr", {31'h0, PSLVERR}, 32'h0);
        chk("pready", {31'h0, PREADY}, 32'h1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: reset asserted while in LAUNCH
        apb_write(4'h0, 32'h5A, e);
        chk("t1_dv_launch", {31'h0, data_valid}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("t1_dv_abort", {31'h0, data_valid}, 32'h0);
        chk("t1_wdata_abort", {24'h0, WDATA}, 32'h0);
        chk("t1_irq_abort", {31'h0, irq}, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        apb_read(4'h8, d, e);
        chk("t1_status", d, 32'h0);

        // 2: basic transfer, 0xA5 out, 0x3C back
        manual = 1'b0; resp = 8'h3C;
        apb_write(4'h0, 32'hA5, e);
        chk("t2_err", {31'h0, e}, 32'h0);
        #4;
        chk("t2_dv_next", {31'h0, data_valid}, 32'h1);
        chk("t2_wdata", {24'h0, WDATA}, 32'hA5);
        apb_read(4'h8, d, e);
        chk("t2_status_busy", d, 32'h1);
        wait_idle("t2_idle");
        chk("t2_dv_low", {31'h0, data_valid}, 32'h0);
        chk("t2_wdata_hold", {24'h0, WDATA}, 32'hA5);
        apb_read(4'h8, d, e);
        chk("t2_status_rx", d, 32'h2);
        apb_read(4'h4, d, e);
        chk("t2_rxdata", d, 32'h3C);
        chk("t2_rx_err", {31'h0, e}, 32'h0);
        apb_read(4'h8, d, e);
        chk("t2_status_clr", d, 32'h0);

        // 3: TXDATA write while busy
        resp = 8'h5E;
        apb_write(4'h0, 32'h11, e);
        chk("t3_first_err", {31'h0, e}, 32'h0);
        apb_write(4'h0, 32'h22, e);
        chk("t3_busy_err", {31'h0, e}, 32'h1);
        chk("t3_wdata", {24'h0, WDATA}, 32'h11);
        apb_read(4'h0, d, e);
        chk("t3_txreg", d, 32'h11);
        apb_read(4'h8, d, e);
        chk("t3_status_ovr", d, 32'h5);
        apb_write(4'h8, 32'h4, e);
        chk("t3_w1c_err", {31'h0, e}, 32'h0);
        apb_read(4'h8, d, e);
        chk("t3_status_w1c", d, 32'h1);
        wait_idle("t3_idle");
        apb_read(4'h4, d, e);
        chk("t3_rxdata", d, 32'h5E);

        // 4: two transfers without reading RXDATA
        resp = 8'h77;
        apb_write(4'h0, 32'h01, e);
        wait_idle("t4_idle1");
        resp = 8'h88;
        apb_write(4'h0, 32'h02, e);
        wait_idle("t4_idle2");
        apb_read(4'h8, d, e);
        chk("t4_status", d, 32'h6);
        apb_read(4'h4, d, e);
        chk("t4_rxdata", d, 32'h88);
        apb_read(4'h8, d, e);
        chk("t4_status_rd", d, 32'h4);
        apb_write(4'h8, 32'h4, e);
        apb_read(4'h8, d, e);
        chk("t4_status_clr", d, 32'h0);

        // 5: interrupt
        apb_write(4'hC, 32'hFFFF_FFFF, e);
        apb_read(4'hC, d, e);
        chk("t5_ctrl", d, 32'h1);
        chk("t5_irq_idle", {31'h0, irq}, 32'h0);
        resp = 8'hC3;
        apb_write(4'h0, 32'h44, e);
        wait_idle("t5_idle");
        chk("t5_irq_set", {31'h0, irq}, 32'h1);
        apb_read(4'h4, d, e);
        chk("t5_rxdata", d, 32'hC3);
        chk("t5_irq_clr", {31'h0, irq}, 32'h0);
        apb_write(4'hC, 32'h0, e);

        // 6: RXDATA read in the CAPTURE cycle, RXDATA write
        manual = 1'b1; man_rdy = 1'b1;
        apb_write(4'h0, 32'h33, e);
        man_rdy = 1'b0;
        @(posedge clk); #1;
        man_rdy = 1'b1; man_rdata = 8'h99;
        apb_read(4'h4, d, e);
        chk("t6_old_rx", d, 32'hC3);
        apb_read(4'h8, d, e);
        chk("t6_status", d, 32'h2);
        apb_read(4'h4, d, e);
        chk("t6_new_rx", d, 32'h99);
        apb_write(4'h4, 32'h12, e);
        chk("t6_rx_wr_err", {31'h0, e}, 32'h1);
        apb_read(4'h8, d, e);
        chk("t6_status_end", d, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
